// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake plus IM SRAM write port between the boot loader (master)
// and the host byte source / SRAM macro side (slave).
interface imem_boot_loader_if #(
  parameter int ADDR_W = 14
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_ceb;
  logic              mem_web;
  logic [31:0]       mem_bweb;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_di;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_ceb, mem_web, mem_bweb, mem_a, mem_di
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_ceb, mem_web, mem_bweb, mem_a, mem_di
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-SRAM boot loader: LEN / words / XOR trailer byte stream in,
// one-cycle SRAM word writes out, CPU held in reset until the image verifies.
module imem_boot_loader #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 1 << ADDR_W,
  parameter int BASE_WORD = 0
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.master  bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] len_q;
  logic [31:0]     acc;
  logic [7:0]      xsum;

  logic        take;
  logic        last_byte;
  logic [31:0] acc_nx;
  logic        len_bad;

  assign bus.rx_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign take         = bus.rx_valid && bus.rx_ready;
  assign last_byte    = (byte_cnt == 2'd3);
  // Little-endian assembly: the newest byte enters at the top and walks down.
  assign acc_nx       = {bus.rx_data, acc[31:8]};
  assign len_bad      = (acc_nx == 32'd0) || (acc_nx > 32'(MAX_WORDS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LEN;
    else      state <= state_nx;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    state_nx = state;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      S_LEN:   if (take && last_byte) state_nx = len_bad ? S_ERR : S_DATA;
      S_DATA:  if (take && last_byte) state_nx = S_WRITE;
      S_WRITE: state_nx = ((word_cnt + 1'b1) == len_q) ? S_CSUM : S_DATA;
      S_CSUM:  if (take) state_nx = (bus.rx_data == xsum) ? S_DONE : S_ERR;
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: state_nx = S_ERR;
    endcase
  end

  // SRAM strobes are registered so they are low for exactly the WRITE cycle,
  // and A/DI change only when a write is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt     <= '0;
      word_cnt     <= '0;
      len_q        <= '0;
      acc          <= '0;
      xsum         <= '0;
      bus.mem_ceb  <= 1'b1;
      bus.mem_web  <= 1'b1;
      bus.mem_bweb <= '1;
      bus.mem_a    <= '0;
      bus.mem_di   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so all registers update together at the edge.
      bus.mem_ceb  <= 1'b1;
      bus.mem_web  <= 1'b1;
      bus.mem_bweb <= '1;
      if (take && (state != S_CSUM)) begin
        acc      <= acc_nx;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (take && (state == S_LEN) && last_byte)
        len_q <= acc_nx[ADDR_W:0];
      if (take && (state == S_DATA)) begin
        xsum <= xsum ^ bus.rx_data;
        if (last_byte) begin
          bus.mem_ceb  <= 1'b0;
          bus.mem_web  <= 1'b0;
          bus.mem_bweb <= '0;
          bus.mem_a    <= ADDR_W'(BASE_WORD) + word_cnt[ADDR_W-1:0];
          bus.mem_di   <= acc_nx;
        end
      end
      if (state == S_WRITE)
        word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and random images compared
// against a stream-parsing reference model.
module tb_imem_boot_loader;
  localparam int ADDR_W    = 4;
  localparam int MAX_WORDS = 1 << ADDR_W;
  localparam int BASE_WORD = 0;

  logic clk = 1'b0;
  logic rst;
  logic cpu_hold, done, error;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(
    .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .BASE_WORD(BASE_WORD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int pulses = 0;

  always @(negedge clk) if (bus.mem_ceb === 1'b0) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [7:0]  stream[$];
  logic [31:0] word_q[$];
  logic [31:0] exp_data[$];
  bit          exp_done, exp_err, exp_len_bad;
  int          n_consume;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Builds LEN bytes, the words in word_q, and optionally the correct trailer.
  task automatic make_stream(input logic [31:0] len, input bit with_trailer);
    logic [7:0] cs;
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(len[8*i +: 8]);
    cs = 8'h00;
    foreach (word_q[w])
      for (int i = 0; i < 4; i++) begin
        stream.push_back(word_q[w][8*i +: 8]);
        cs = cs ^ word_q[w][8*i +: 8];
      end
    if (with_trailer) stream.push_back(cs);
  endtask

  // Parses the stream by the format rules: expected writes, outcome, bytes consumed.
  task automatic model();
    logic [31:0] n;
    logic [7:0]  cs;
    n = {stream[3], stream[2], stream[1], stream[0]};
    exp_data.delete();
    exp_done    = 1'b0;
    exp_err     = 1'b0;
    exp_len_bad = (n == 0) || (n > MAX_WORDS);
    if (exp_len_bad) begin
      exp_err   = 1'b1;
      n_consume = 4;
    end else begin
      cs = 8'h00;
      for (int w = 0; w < int'(n); w++) begin
        exp_data.push_back({stream[4+4*w+3], stream[4+4*w+2], stream[4+4*w+1], stream[4+4*w]});
        for (int i = 0; i < 4; i++) cs = cs ^ stream[4+4*w+i];
      end
      n_consume = 4 + 4 * int'(n) + 1;
      if (stream[n_consume-1] == cs) exp_done = 1'b1;
      else                           exp_err  = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Offers byte k after a gap; checks the SRAM port in the cycle after acceptance.
  task automatic send_byte(input int k, input int gap);
    int n;
    int w;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = stream[k];
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("rx_ready_timeout", 32'(n), 32'd0);
      bus.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    @(negedge clk);
    if (k >= 4 && ((k - 4) / 4) < exp_data.size() && ((k - 4) % 4) == 3) begin
      w = (k - 4) / 4;
      check("wr_ceb",  32'(bus.mem_ceb), 32'd0);
      check("wr_web",  32'(bus.mem_web), 32'd0);
      check("wr_bweb", bus.mem_bweb, 32'h0);
      check("wr_a",    32'(bus.mem_a), 32'((BASE_WORD + w) % (1 << ADDR_W)));
      check("wr_di",   bus.mem_di, exp_data[w]);
    end else begin
      check("idle_ceb", 32'(bus.mem_ceb), 32'd1);
    end
    if (k == 3 && exp_len_bad) begin
      check("len_err_now", 32'(error), 32'd1);
      check("len_err_rdy", 32'(bus.rx_ready), 32'd0);
    end
  endtask

  task automatic run_stream(input int gap_min, input int gap_max);
    int base;
    model();
    base = pulses;
    for (int k = 0; k < n_consume; k++)
      send_byte(k, $urandom_range(gap_max, gap_min));
    repeat (3) @(negedge clk);
    check("n_writes", 32'(pulses - base), 32'(exp_data.size()));
    check("done",     32'(done),          32'(exp_done));
    check("error",    32'(error),         32'(exp_err));
    check("cpu_hold", 32'(cpu_hold),      32'(!exp_done));
    check("end_rdy",  32'(bus.rx_ready),  32'd0);
    check("end_ceb",  32'(bus.mem_ceb),   32'd1);
  endtask

  initial begin
    int base;
    int nw;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ceb",  32'(bus.mem_ceb), 32'd1);
    check("rst_web",  32'(bus.mem_web), 32'd1);
    check("rst_bweb", bus.mem_bweb,     32'hFFFF_FFFF);
    check("rst_a",    32'(bus.mem_a),   32'd0);
    check("rst_di",   bus.mem_di,       32'd0);
    check("rst_hold", 32'(cpu_hold),    32'd1);
    check("rst_done", 32'(done),        32'd0);
    check("rst_err",  32'(error),       32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdy",  32'(bus.rx_ready), 32'd1);

    // Two-word image, back-to-back bytes; trailer computed from the XOR rule.
    word_q = '{32'h0000_0013, 32'h0010_0093};
    make_stream(32'd2, 1'b1);
    run_stream(0, 0);

    // Zero length
    do_reset();
    word_q.delete();
    make_stream(32'd0, 1'b0);
    run_stream(0, 0);

    // Wrong checksum on a single word (correct trailer would be 0x22)
    do_reset();
    word_q = '{32'hDEAD_BEEF};
    make_stream(32'd1, 1'b1);
    check("csum_ref", 32'(stream[stream.size()-1]), 32'h22);
    stream[stream.size()-1] = 8'h00;
    run_stream(0, 0);

    // First image with 3-cycle gaps before every byte
    do_reset();
    word_q = '{32'h0000_0013, 32'h0010_0093};
    make_stream(32'd2, 1'b1);
    run_stream(3, 3);

    // Reset after the 6th byte, then a full reload
    do_reset();
    model();
    base = pulses;
    for (int k = 0; k < 6; k++) send_byte(k, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_writes", 32'(pulses - base), 32'd0);
    check("mid_ceb",    32'(bus.mem_ceb),   32'd1);
    check("mid_a",      32'(bus.mem_a),     32'd0);
    check("mid_hold",   32'(cpu_hold),      32'd1);
    rst = 1'b1;
    @(negedge clk);
    run_stream(0, 1);

    // Length one past the limit, and a length with only the top byte wrong
    do_reset();
    word_q.delete();
    make_stream(32'(MAX_WORDS + 1), 1'b0);
    run_stream(0, 0);
    do_reset();
    make_stream(32'h0100_0001, 1'b0);
    run_stream(0, 0);

    // Largest legal image
    do_reset();
    word_q.delete();
    for (int i = 0; i < MAX_WORDS; i++) word_q.push_back($urandom);
    make_stream(32'(MAX_WORDS), 1'b1);
    run_stream(0, 1);

    // Random images, random gaps, occasional corrupted trailer
    for (int it = 0; it < 8; it++) begin
      do_reset();
      word_q.delete();
      nw = $urandom_range(6, 1);
      for (int i = 0; i < nw; i++) word_q.push_back($urandom);
      make_stream(32'(nw), 1'b1);
      if ($urandom_range(3, 0) == 0)
        stream[stream.size()-1] = stream[stream.size()-1] ^ 8'(1 << $urandom_range(7, 0));
      run_stream(0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
